fft_bin_serializer: RTL and testbench
=====================================

Name: fft_bin_serializer

Overview:
- Downstream consumer of the 8-point 16-bit FFT stage.
- Captures all eight complex output bins (r0..r7, i0..i7) in one cycle when the FFT signals completion.
- Streams the bins out one per beat under a valid/ready handshake, with a squared magnitude per bin.
- Reports the peak-magnitude bin at frame end.
- Decouples the parallel FFT output from a narrow serial consumer (UART/display/logging path).

Parameters:
- W, 16, bin component width (two's-complement signed).
- NBINS, 8, bins per frame (fixed at 8; index width 3).

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  one-cycle pulse from FFT stage: r0..r7/i0..i7 are valid this cycle.
- r0..r7  input  16 each  real parts of bins 0..7, signed.
- i0..i7  input  16 each  imaginary parts of bins 0..7, signed.
- out_ready  input  1  downstream accepts current beat.
- out_valid  output  1  current beat valid.
- out_index  output  3  bin number of current beat.
- out_re  output  16  real part of current bin.
- out_im  output  16  imaginary part of current bin.
- out_mag  output  32  re*re + im*im, unsigned.
- out_last  output  1  high with out_valid on bin 7.
- busy  output  1  frame held / streaming.
- frame_done  output  1  one-cycle pulse after bin 7 accepted.
- peak_index  output  3  bin with largest out_mag in last completed frame.
- peak_mag  output  32  that magnitude.
- overrun  output  1  sticky: in_valid arrived while busy and was dropped.

Behaviour:
- Everything is synchronous to clk. The design has one clock domain and one synchronous, active-high reset, rst.
- Reset values:
  - out_valid=0, out_index=0, out_last=0, busy=0, frame_done=0, overrun=0.
  - peak_index=0, peak_mag=0, internal running peak=0.
  - Bin buffer cleared to 0, so out_re=out_im=0 and out_mag=0.
- States: IDLE, SEND.
- IDLE:
  - On in_valid, latch all 16 inputs into the buffer.
  - Set index=0 and go to SEND. out_valid=1 on the next cycle, so capture-to-first-beat latency is 1 cycle.
- SEND:
  - out_valid=1, busy=1.
  - out_re/out_im = buffer[index]; out_mag is computed from those registered values.
  - Beat accepted when out_valid && out_ready.
  - Non-final accepted beat: index increments.
  - Accepted beat with index=7: go to IDLE and pulse frame_done next cycle.
  - Without out_ready: hold index and all outputs stable, for any number of cycles.
- Arithmetic:
  - Products are signed 16x16 -> 32.
  - The sum is taken as unsigned 32-bit with no overflow. Maximum is (-32768)^2 * 2 = 0x80000000.
- Peak tracking:
  - Updated on each accepted beat.
  - Bin 0 always loads the running peak.
  - Later bins replace it only if mag > running peak (strict), so ties keep the lower index.
  - On frame completion, copy the running peak into peak_index/peak_mag, registered in the same cycle frame_done rises.
  - Held until the next frame_done.
- Back-to-back frames: in_valid in the same cycle the bin-7 beat is accepted captures the new frame. State stays SEND with index=0, no idle cycle, and frame_done still pulses for the old frame.
- Overrun:
  - in_valid while busy, other than the back-to-back case, is dropped.
  - The buffer is untouched and overrun sets.
  - overrun clears only on rst.
- out_last = out_valid && index==7.
- Reset mid-frame returns to IDLE next cycle with all reset values. The partial frame is discarded and no frame_done is generated.
- in_valid asserted together with rst is ignored.

Test Plan:
- Uniform frame:
  - Stimulus: all r=0x0100, i=0; out_ready held 1.
  - Response: 8 consecutive beats, index 0..7, each out_mag=0x00010000, out_last on beat 7.
  - frame_done one cycle after beat 7; peak_index=0, peak_mag=0x00010000.
- Extremes:
  - Stimulus: bin3 r=0x8000, i=0x8000; bin5 r=0x7FFF, i=0; others 0.
  - Response: beat3 mag=0x80000000, beat5 mag=0x3FFF0001; peak_index=3, peak_mag=0x80000000.
- Backpressure:
  - Stimulus: out_ready toggles 1,0,0,1 pattern.
  - Response: index/out_re/out_im/out_mag stable while out_ready=0; all 8 bins delivered exactly once in order.
- Back-to-back:
  - Stimulus: second in_valid (all r=0x0002) coincident with acceptance of frame-1 bin 7.
  - Response: next cycle shows index=0, out_re=0x0002, out_valid=1; frame_done pulses once for frame 1; overrun stays 0.
- Overrun:
  - Stimulus: in_valid during index=2 with out_ready=0.
  - Response: overrun=1; remaining beats carry original frame data; overrun persists until rst.
- Reset mid-frame:
  - Stimulus: rst at index=4.
  - Response: next cycle out_valid=0, busy=0, out_index=0, peak_mag=0; no frame_done pulse.

Source files
------------

// File: rtl/fft_bin_serializer.sv
// fft_bin_serializer: captures an 8-bin complex FFT frame and streams bins with squared magnitude and peak tracking
module fft_bin_serializer #(
  parameter int W     = 16,
  parameter int NBINS = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  input  logic signed [W-1:0]  r0,
  input  logic signed [W-1:0]  r1,
  input  logic signed [W-1:0]  r2,
  input  logic signed [W-1:0]  r3,
  input  logic signed [W-1:0]  r4,
  input  logic signed [W-1:0]  r5,
  input  logic signed [W-1:0]  r6,
  input  logic signed [W-1:0]  r7,
  input  logic signed [W-1:0]  i0,
  input  logic signed [W-1:0]  i1,
  input  logic signed [W-1:0]  i2,
  input  logic signed [W-1:0]  i3,
  input  logic signed [W-1:0]  i4,
  input  logic signed [W-1:0]  i5,
  input  logic signed [W-1:0]  i6,
  input  logic signed [W-1:0]  i7,
  input  logic                 out_ready,
  output logic                 out_valid,
  output logic [2:0]           out_index,
  output logic signed [W-1:0]  out_re,
  output logic signed [W-1:0]  out_im,
  output logic [2*W-1:0]       out_mag,
  output logic                 out_last,
  output logic                 busy,
  output logic                 frame_done,
  output logic [2:0]           peak_index,
  output logic [2*W-1:0]       peak_mag,
  output logic                 overrun
);
  typedef enum logic {IDLE, SEND} state_t;
  state_t state_q, state_d;
  logic signed [W-1:0] re_q [NBINS];
  logic signed [W-1:0] re_d [NBINS];
  logic signed [W-1:0] im_q [NBINS];
  logic signed [W-1:0] im_d [NBINS];
  logic [2:0] idx_q, idx_d, run_idx_q, run_idx_d, peak_idx_q, peak_idx_d;
  logic [2*W-1:0] run_mag_q, run_mag_d, peak_mag_q, peak_mag_d;
  logic frame_done_q, frame_done_d, overrun_q, overrun_d;
  logic signed [2*W-1:0] pr, pi;
  logic acc, last_acc, cap, upd;
  assign out_valid  = state_q == SEND;
  assign busy       = state_q == SEND;
  assign out_index  = idx_q;
  assign out_re     = re_q[idx_q];
  assign out_im     = im_q[idx_q];
  assign pr         = out_re * out_re;
  assign pi         = out_im * out_im;
  assign out_mag    = $unsigned(pr) + $unsigned(pi);
  assign out_last   = out_valid && idx_q == 3'd7;
  assign frame_done = frame_done_q;
  assign peak_index = peak_idx_q;
  assign peak_mag   = peak_mag_q;
  assign overrun    = overrun_q;
  assign acc        = out_valid && out_ready;
  assign last_acc   = acc && out_last;
  assign cap        = in_valid && (!out_valid || last_acc);
  assign upd        = acc && (idx_q == 3'd0 || out_mag > run_mag_q);
  always_comb begin
    state_d      = cap ? SEND : last_acc ? IDLE : state_q;
    idx_d        = cap ? 3'd0 : acc ? idx_q + 3'd1 : idx_q;
    re_d         = re_q;
    im_d         = im_q;
    if (cap) begin
      re_d = '{r0, r1, r2, r3, r4, r5, r6, r7};
      im_d = '{i0, i1, i2, i3, i4, i5, i6, i7};
    end
    run_idx_d    = upd ? idx_q : run_idx_q;
    run_mag_d    = upd ? out_mag : run_mag_q;
    peak_idx_d   = last_acc ? run_idx_d : peak_idx_q;
    peak_mag_d   = last_acc ? run_mag_d : peak_mag_q;
    frame_done_d = last_acc;
    overrun_d    = overrun_q | (in_valid && out_valid && !last_acc);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      re_q         <= '{default: '0};
      im_q         <= '{default: '0};
      run_idx_q    <= '0;
      run_mag_q    <= '0;
      peak_idx_q   <= '0;
      peak_mag_q   <= '0;
      frame_done_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      re_q         <= re_d;
      im_q         <= im_d;
      run_idx_q    <= run_idx_d;
      run_mag_q    <= run_mag_d;
      peak_idx_q   <= peak_idx_d;
      peak_mag_q   <= peak_mag_d;
      frame_done_q <= frame_done_d;
      overrun_q    <= overrun_d;
    end
  end
endmodule

// File: tb/tb_fft_bin_serializer.sv
// tb_fft_bin_serializer: scoreboard bench streaming directed frames through fft_bin_serializer
module tb_fft_bin_serializer;
  logic clk = 0, rst = 1, in_valid = 0, out_ready = 0;
  logic [15:0] fr_re [8];
  logic [15:0] fr_im [8];
  logic out_valid, out_last, busy, frame_done, overrun;
  logic [2:0] out_index, peak_index;
  logic [15:0] out_re, out_im;
  logic [31:0] out_mag, peak_mag;
  int total = 0, bad = 0;
  typedef struct {logic [2:0] idx; logic [15:0] re; logic [15:0] im; logic [31:0] mag; logic last;} beat_t;
  typedef struct {logic [2:0] idx; logic [31:0] mag;} peak_t;
  beat_t bq[$];
  peak_t pq[$];
  fft_bin_serializer dut (
    .clk(clk), .rst(rst), .in_valid(in_valid),
    .r0(fr_re[0]), .r1(fr_re[1]), .r2(fr_re[2]), .r3(fr_re[3]),
    .r4(fr_re[4]), .r5(fr_re[5]), .r6(fr_re[6]), .r7(fr_re[7]),
    .i0(fr_im[0]), .i1(fr_im[1]), .i2(fr_im[2]), .i3(fr_im[3]),
    .i4(fr_im[4]), .i5(fr_im[5]), .i6(fr_im[6]), .i7(fr_im[7]),
    .out_ready(out_ready), .out_valid(out_valid), .out_index(out_index),
    .out_re(out_re), .out_im(out_im), .out_mag(out_mag), .out_last(out_last),
    .busy(busy), .frame_done(frame_done), .peak_index(peak_index),
    .peak_mag(peak_mag), .overrun(overrun)
  );
  always #5 clk = ~clk;
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  function automatic logic [31:0] mag(input logic [15:0] a, input logic [15:0] b);
    logic signed [31:0] x, y;
    x = {{16{a[15]}}, a};
    y = {{16{b[15]}}, b};
    return x * x + y * y;
  endfunction
  task automatic set_frame(input logic [15:0] rv, input logic [15:0] iv);
    for (int k = 0; k < 8; k++) begin
      fr_re[k] = rv;
      fr_im[k] = iv;
    end
  endtask
  task automatic push_frame();
    peak_t p;
    beat_t b;
    for (int k = 0; k < 8; k++) begin
      b.idx = 3'(k);
      b.re = fr_re[k];
      b.im = fr_im[k];
      b.mag = mag(fr_re[k], fr_im[k]);
      b.last = k == 7;
      bq.push_back(b);
      if (k == 0 || b.mag > p.mag) begin
        p.idx = 3'(k);
        p.mag = b.mag;
      end
    end
    pq.push_back(p);
  endtask
  task automatic capture();
    push_frame();
    in_valid = 1;
    step();
    in_valid = 0;
    chk("first_beat_valid", {31'd0, out_valid}, 1);
  endtask
  task automatic run(input int nacc, input int pat, input bit b2b);
    int acc = 0, cyc = 0;
    bit lastp;
    beat_t e;
    peak_t p;
    while (acc < nacc && cyc < 200) begin
      out_ready = pat == 0 ? 1'b1 : (cyc % 4 == 0 || cyc % 4 == 3);
      lastp = 0;
      if (out_valid) begin
        chk("beat_expected", {31'd0, bq.size() != 0}, 1);
        if (bq.size() != 0) begin
          e = bq[0];
          chk("out_index", {29'd0, out_index}, {29'd0, e.idx});
          chk("out_re", {16'd0, out_re}, {16'd0, e.re});
          chk("out_im", {16'd0, out_im}, {16'd0, e.im});
          chk("out_mag", out_mag, e.mag);
          chk("out_last", {31'd0, out_last}, {31'd0, e.last});
          if (out_ready) begin
            void'(bq.pop_front());
            acc++;
            lastp = e.last;
            if (lastp && b2b) begin
              set_frame(16'h0002, 16'h0000);
              push_frame();
              in_valid = 1;
            end
          end
        end
      end
      step();
      in_valid = 0;
      chk("frame_done", {31'd0, frame_done}, {31'd0, lastp});
      if (lastp && pq.size() != 0) begin
        p = pq.pop_front();
        chk("peak_index", {29'd0, peak_index}, {29'd0, p.idx});
        chk("peak_mag", peak_mag, p.mag);
      end
      cyc++;
    end
    chk("run_timeout", {31'd0, acc >= nacc}, 1);
  endtask
  initial begin
    set_frame(16'h0000, 16'h0000);
    step();
    in_valid = 1;
    step();
    in_valid = 0;
    step();
    rst = 0;
    chk("rst_out_valid", {31'd0, out_valid}, 0);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_out_index", {29'd0, out_index}, 0);
    chk("rst_out_last", {31'd0, out_last}, 0);
    chk("rst_frame_done", {31'd0, frame_done}, 0);
    chk("rst_overrun", {31'd0, overrun}, 0);
    chk("rst_peak_index", {29'd0, peak_index}, 0);
    chk("rst_peak_mag", peak_mag, 0);
    chk("rst_out_mag", out_mag, 0);
    chk("rst_out_re", {16'd0, out_re}, 0);
    step();
    chk("rst_still_idle", {31'd0, out_valid}, 0);
    set_frame(16'h0100, 16'h0000);
    capture();
    run(8, 0, 0);
    chk("uniform_peak_index", {29'd0, peak_index}, 0);
    chk("uniform_peak_mag", peak_mag, 32'h00010000);
    chk("uniform_idle", {31'd0, busy}, 0);
    step();
    chk("frame_done_single", {31'd0, frame_done}, 0);
    set_frame(16'h0000, 16'h0000);
    fr_re[3] = 16'h8000;
    fr_im[3] = 16'h8000;
    fr_re[5] = 16'h7FFF;
    capture();
    run(8, 0, 0);
    chk("ext_peak_index", {29'd0, peak_index}, 3);
    chk("ext_peak_mag", peak_mag, 32'h80000000);
    for (int k = 0; k < 8; k++) begin
      fr_re[k] = 16'(16'h0010 * k - 16'h0040);
      fr_im[k] = 16'(16'h0300 - 16'h0011 * k);
    end
    capture();
    run(8, 1, 0);
    set_frame(16'h0100, 16'hFF00);
    fr_re[6] = 16'hF000;
    capture();
    run(8, 0, 1);
    chk("b2b_out_valid", {31'd0, out_valid}, 1);
    chk("b2b_out_index", {29'd0, out_index}, 0);
    chk("b2b_out_re", {16'd0, out_re}, 16'h0002);
    chk("b2b_overrun", {31'd0, overrun}, 0);
    run(8, 0, 0);
    chk("b2b_peak_mag", peak_mag, 32'h00000004);
    for (int k = 0; k < 8; k++) begin
      fr_re[k] = 16'(16'h0100 * (k + 1));
      fr_im[k] = 16'(16'hFFF0 + k);
    end
    capture();
    run(2, 0, 0);
    out_ready = 0;
    set_frame(16'h1234, 16'h4321);
    in_valid = 1;
    step();
    in_valid = 0;
    chk("ovr_set", {31'd0, overrun}, 1);
    chk("ovr_index_held", {29'd0, out_index}, 2);
    run(6, 1, 0);
    step();
    chk("ovr_sticky", {31'd0, overrun}, 1);
    set_frame(16'h0050, 16'h0007);
    capture();
    run(4, 0, 0);
    chk("mid_index", {29'd0, out_index}, 4);
    rst = 1;
    step();
    chk("mid_out_valid", {31'd0, out_valid}, 0);
    chk("mid_busy", {31'd0, busy}, 0);
    chk("mid_out_index", {29'd0, out_index}, 0);
    chk("mid_peak_mag", peak_mag, 0);
    chk("mid_overrun", {31'd0, overrun}, 0);
    chk("mid_frame_done", {31'd0, frame_done}, 0);
    rst = 0;
    bq.delete();
    pq.delete();
    step();
    chk("mid_no_frame_done", {31'd0, frame_done}, 0);
    chk("mid_stays_idle", {31'd0, out_valid}, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
